serial_port: RTL and testbench
==============================

Name: serial_port

Overview:
Memory-mapped RS-232 UART sitting beside the memory controller on the CPU data path. The memory controller decodes the serial-port addresses and drives this block's select/strobe lines instead of the external SRAM. It serialises CPU writes onto txd and deserialises rxd into a small receive FIFO that the CPU polls through a status word. Everything runs on the board clock (clk), not the hand-stepped CPU clock.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200 baud); minimum 4.
RX_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  board clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
sel  in  1  block selected this cycle; rd/wr are ignored when low
addrLow  in  1  0 = data register, 1 = status register
rd  in  1  one-cycle read strobe
wr  in  1  one-cycle write strobe
dataIn  in  16  write data; only bits [7:0] are used
dataOut  out  16  registered read data
txd  out  1  serial output; idle high
rxd  in  1  serial input; asynchronous

Behaviour:
- Reset values: txd=1, dataOut=16'h0000, FIFO empty, txReady=1, overrun=0, frameErr=0. TX and RX FSMs go to IDLE.
- Reset mid-frame abandons the frame. txd is high from the next edge.
- Read path:
  - Latency is 1 cycle: dataOut is updated on the edge that samples sel&rd. It holds its value otherwise.
  - Data read: dataOut={8'h00, FIFO head} and the head is popped. If the FIFO is empty, dataOut=16'h0000 and there is no pop.
  - Status read: dataOut={12'h000, frameErr, overrun, rxAvail, txReady}. Reading status clears overrun and frameErr. If an error sets in the same cycle, set wins.
  - rxAvail = FIFO not empty (combinational).
- Writes:
  - sel&wr with addrLow=0 while txReady=1: latch dataIn[7:0] and start TX. txReady=0 from the next cycle.
  - sel&wr with addrLow=0 while txReady=0: ignored and no flag is set.
  - Writes with addrLow=1 are ignored.
  - rd and wr asserted together: wr is ignored.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state or bit lasts exactly CLKS_PER_BIT cycles.
  - txd=0 in START and is driven the cycle after the write.
  - txReady returns to 1 on the cycle after the STOP period ends. Frame = 10*CLKS_PER_BIT cycles.
- RX path, synchroniser and start detection:
  - rxd passes through a 2-flop synchroniser.
  - IDLE detects a 1->0 transition of the synchronised rxd.
  - START waits CLKS_PER_BIT/2 cycles and resamples. If high, it is a false start and the FSM returns to IDLE.
- RX FSM, data and stop:
  - DATA samples 8 bits at mid-bit, spaced CLKS_PER_BIT apart, LSB first.
  - STOP samples one bit-period later. If the sample is 1, the byte is pushed. If it is 0, frameErr=1 and the byte is discarded.
  - The FSM then returns to IDLE, waiting for rxd high before re-arming.
- FIFO:
  - Circular buffer with log2(RX_DEPTH)+1-bit read/write pointers; wrap-around is natural.
  - Push when full: byte dropped, overrun=1.
  - Pop and push in the same cycle when full: both occur, no overrun.
  - Pop and push in the same cycle when empty: the data read returns 0 and the pushed byte stays.

Test Plan:
(CLKS_PER_BIT=4, RX_DEPTH=4 for all.)
- Reset, then status read -> dataOut=16'h0001 one cycle later; txd=1.
- Write 16'h1234 to data -> txd starts 0 next cycle, then bits 0,0,1,0,1,1,0,0, then stop 1. Each level holds 4 cycles. Status=16'h0000 during the frame, 16'h0001 after 40 cycles. A second write mid-frame does not change the frame.
- Drive rxd frame 0xA5 -> status=16'h0003. Data read returns 16'h00A5, then status=16'h0001.
- Drive 5 frames 0x01..0x05 with no reads -> status=16'h0007. Four data reads return 0x01..0x04 in order. A fifth read returns 16'h0000. The following status read is 16'h0001, since overrun was cleared by the first status read.
- rxd frame with stop bit 0 -> status=16'h0009, FIFO empty. Second status read -> 16'h0001.
- 1-cycle low glitch on rxd -> no push, status unchanged. Assert rst mid-TX-frame -> txd=1 next cycle and status=16'h0001.

Source files
------------

// File: rtl/serial_port.sv
// serial_port: memory-mapped 8N1 UART with a polled status word and a small receive FIFO.
//
// Ports:
//   clk      board clock, rising edge
//   rst      synchronous active-high reset
//   sel      block selected; rd/wr ignored when low
//   addrLow  0 = data register, 1 = status register
//   rd, wr   one-cycle strobes (rd wins when both are high)
//   dataIn   write data, bits [7:0] used
//   dataOut  registered read data
//   txd      serial output, idle high
//   rxd      asynchronous serial input
//
// Status word: {12'h000, frameErr, overrun, rxAvail, txReady}.
module serial_port #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned RX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        addrLow,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] dataIn,
    output logic [15:0] dataOut,
    output logic        txd,
    input  logic        rxd
);

    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // TX state
    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            txd_q, txd_d;

    // RX state
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_sync1_q, rx_sync1_d;
    logic            rx_sync2_q, rx_sync2_d;
    logic            rx_prev_q, rx_prev_d;

    // FIFO and register file
    logic [7:0]      fifo_q [RX_DEPTH];
    logic [7:0]      fifo_d [RX_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic [15:0]     data_out_q, data_out_d;

    logic rd_en, wr_en, data_rd, status_rd;
    logic tx_ready, tx_start;
    logic fifo_empty, fifo_full, rx_avail;
    logic push_req, push, pop, ovf_set, frame_err_set;
    logic [7:0] head;

    logic unused_data_hi;
    assign unused_data_hi = ^dataIn[15:8];

    // Bus decode; a write coinciding with a read is dropped.
    assign rd_en     = sel & rd;
    assign wr_en     = sel & wr & ~rd;
    assign data_rd   = rd_en & ~addrLow;
    assign status_rd = rd_en & addrLow;

    assign tx_ready = (tx_state_q == TxIdle);
    assign tx_start = wr_en & ~addrLow & tx_ready;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rx_avail   = ~fifo_empty;
    assign head       = fifo_q[rd_ptr_q[AW-1:0]];

    assign pop     = data_rd & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push    = push_req & (~fifo_full | pop);
    assign ovf_set = push_req & fifo_full & ~pop;

    // TX next state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        unique case (tx_state_q)
            TxIdle: begin
                txd_d = 1'b1;
                if (tx_start) begin
                    tx_state_d = TxStart;
                    tx_cnt_d   = '0;
                    tx_shift_d = dataIn[7:0];
                    txd_d      = 1'b0;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxStop: begin
                if (tx_cnt_q == BitLast) begin
                    tx_state_d = TxIdle;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    // RX next state
    always_comb begin
        rx_sync1_d    = rxd;
        rx_sync2_d    = rx_sync1_q;
        rx_prev_d     = rx_sync2_q;
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        push_req      = 1'b0;
        frame_err_set = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                // Falling edge only: a line stuck low after a bad stop bit cannot re-arm.
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    if (rx_sync2_q) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err_set = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    // FIFO, flags and read data
    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q[AW-1:0]] = rx_shift_q;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        // Error set beats the clear-on-read.
        overrun_d   = (overrun_q & ~status_rd) | ovf_set;
        frame_err_d = (frame_err_q & ~status_rd) | frame_err_set;

        data_out_d = data_out_q;
        if (data_rd) begin
            data_out_d = fifo_empty ? 16'h0000 : {8'h00, head};
        end else if (status_rd) begin
            data_out_d = {12'h000, frame_err_q, overrun_q, rx_avail, tx_ready};
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        if (rst) begin
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'h00;
            txd_q       <= 1'b1;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_prev_q   <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            data_out_q  <= 16'h0000;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            txd_q       <= txd_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_sync1_q  <= rx_sync1_d;
            rx_sync2_q  <= rx_sync2_d;
            rx_prev_q   <= rx_prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            data_out_q  <= data_out_d;
        end
    end

    assign dataOut = data_out_q;
    assign txd     = txd_q;

endmodule

// File: tb/tb_serial_port.sv
module tb_serial_port;

    localparam int C = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst, sel, addrLow, rd, wr, rxd;
    logic [15:0] dataIn;
    logic [15:0] dataOut;
    logic        txd;

    always #5 clk = ~clk;

    serial_port #(.CLKS_PER_BIT(C), .RX_DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .addrLow (addrLow),
        .rd      (rd),
        .wr      (wr),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .txd     (txd),
        .rxd     (rxd)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // tx_k counts clock edges since the accepted write (0 = idle); the frame is
    // ten levels of C cycles: start 0, data LSB first, stop 1.
    int          tx_k = 0;
    logic [7:0]  tx_byte = 8'h00;
    logic [7:0]  fifo_m[$];
    bit          ovr_m = 0, ferr_m = 0;
    logic [15:0] exp_dout = 16'h0000;
    logic        exp_txd = 1'b1;
    bit          model_ok = 0;
    bit          ready_m, acc_m;

    function automatic logic tx_level(input int k, input logic [7:0] b);
        int idx;
        if (k == 0) return 1'b1;
        idx = (k - 1) / C;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            tx_k = 0;
            fifo_m.delete();
            ovr_m    = 0;
            ferr_m   = 0;
            exp_dout = 16'h0000;
            model_ok = 1;
        end else begin
            ready_m = (tx_k == 0);
            if (sel && rd) begin
                if (!addrLow) begin
                    if (fifo_m.size() > 0) exp_dout = {8'h00, fifo_m.pop_front()};
                    else exp_dout = 16'h0000;
                end else begin
                    exp_dout = {12'h000, ferr_m, ovr_m, fifo_m.size() != 0, ready_m};
                    ferr_m = 0;
                    ovr_m  = 0;
                end
            end
            acc_m = sel && wr && !rd && !addrLow && ready_m;
            if (tx_k != 0) tx_k = (tx_k == 10 * C) ? 0 : tx_k + 1;
            if (acc_m) begin
                tx_k    = 1;
                tx_byte = dataIn[7:0];
            end
        end
        exp_txd = tx_level(tx_k, tx_byte);
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("txd_cycle", {15'h0, txd}, {15'h0, exp_txd});
            chk("dout_cycle", dataOut, exp_dout);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cpu_op(input bit a, input bit r, input bit w, input logic [15:0] d);
        @(posedge clk); #1;
        sel = 1'b1; addrLow = a; rd = r; wr = w; dataIn = d;
        @(posedge clk); #1;
        sel = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input bit a, output logic [15:0] v);
        cpu_op(a, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        v = dataOut;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_level(input logic v);
        rxd = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    // Drives one frame, lets the receiver finish, then posts the outcome to the model.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        @(posedge clk); #1;
        rx_level(1'b0);
        for (int i = 0; i < 8; i++) rx_level(b[i]);
        rx_level(stop_ok);
        rxd = 1'b1;
        idle(C + 3);
        if (stop_ok) begin
            if (fifo_m.size() < D) fifo_m.push_back(b);
            else ovr_m = 1;
        end else begin
            ferr_m = 1;
        end
    endtask

    logic [15:0] v;
    logic        lit_tx [10];

    initial begin
        rst = 1'b1; sel = 1'b0; addrLow = 1'b0; rd = 1'b0; wr = 1'b0;
        dataIn = 16'h0000; rxd = 1'b1;
        lit_tx = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        idle(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_txd", {15'h0, txd}, 16'h0001);
        chk("reset_dout", dataOut, 16'h0000);
        rd_reg(1'b1, v);
        chk("reset_status", v, 16'h0001);

        // TX frame of 0x34, with a status read and an ignored write mid-frame
        cpu_op(1'b0, 1'b0, 1'b1, 16'h1234);
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    if (i > 0) repeat (C) @(negedge clk);
                    chk("tx_literal_bit", {15'h0, txd}, {15'h0, lit_tx[i]});
                end
            end
            begin
                idle(5);
                rd_reg(1'b1, v);
                chk("status_tx_busy", v, 16'h0000);
                cpu_op(1'b0, 1'b0, 1'b1, 16'h00FF);
            end
        join
        idle(6);
        rd_reg(1'b1, v);
        chk("status_tx_done", v, 16'h0001);

        // Single received byte
        send_frame(8'hA5, 1'b1);
        rd_reg(1'b1, v);
        chk("status_rx_avail", v, 16'h0003);
        rd_reg(1'b0, v);
        chk("data_a5", v, 16'h00A5);
        rd_reg(1'b1, v);
        chk("status_after_pop", v, 16'h0001);

        // Overrun
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        rd_reg(1'b1, v);
        chk("status_overrun", v, 16'h0007);
        for (int b = 1; b <= 4; b++) begin
            rd_reg(1'b0, v);
            chk("data_in_order", v, 16'(b));
        end
        rd_reg(1'b0, v);
        chk("data_empty", v, 16'h0000);
        rd_reg(1'b1, v);
        chk("status_overrun_cleared", v, 16'h0001);

        // Framing error
        send_frame(8'h3C, 1'b0);
        rd_reg(1'b1, v);
        chk("status_frame_err", v, 16'h0009);
        rd_reg(1'b1, v);
        chk("status_ferr_cleared", v, 16'h0001);
        rd_reg(1'b0, v);
        chk("data_after_ferr", v, 16'h0000);

        // One-cycle glitch is a false start
        @(posedge clk); #1;
        rxd = 1'b0;
        idle(1);
        rxd = 1'b1;
        idle(3 * C);
        rd_reg(1'b1, v);
        chk("status_glitch", v, 16'h0001);

        // Randomised traffic against the model
        for (int n = 0; n < 200; n++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: send_frame(8'($urandom), ($urandom % 6) != 0);
                3, 4:    cpu_op(1'b0, 1'b1, 1'b0, 16'h0000);
                5, 6:    cpu_op(1'b1, 1'b1, 1'b0, 16'h0000);
                7:       cpu_op(1'b0, 1'b0, 1'b1, 16'($urandom));
                8:       idle($urandom_range(1, 30));
                default: cpu_op(1'($urandom), 1'($urandom), 1'b1, 16'($urandom));
            endcase
        end
        idle(10 * C + 4);
        rd_reg(1'b1, v);
        chk("status_random_end", v[0] ? 16'h0001 : 16'h0000, 16'h0001);

        // Reset in the middle of a TX frame
        cpu_op(1'b0, 1'b0, 1'b1, 16'h005A);
        idle(10);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_tx_txd", {15'h0, txd}, 16'h0001);
        rd_reg(1'b1, v);
        chk("rst_mid_tx_status", v, 16'h0001);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
